pc_sequencer: RTL
=================

# pc_sequencer

Program-counter sequencer for the pipelined MIPS core's fetch stage. It holds the PC register and drives both data inputs and the select of the next-PC 2:1 multiplexer: sequential PC+4 on input 0, the latched branch/jump target on input 1. It takes the multiplexer output back as the next PC. A small run/step/halt state machine lets the debug unit run the program continuously, single-step it, or freeze it on HALT.

## Interface
Parameters:
- PC_WIDTH, 32, width of PC, target and cycle counter
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- i_run  in  1  level; debug unit requests continuous execution
- i_step  in  1  one-cycle pulse; debug unit requests one advance
- i_stall  in  1  hazard-unit stall; blocks PC advance
- i_halt  in  1  HALT instruction reached write-back
- i_branch_valid  in  1  one-cycle pulse; a taken branch or jump was resolved
- i_branch_target  in  PC_WIDTH  target address, sampled when i_branch_valid is high
- i_next_pc  in  PC_WIDTH  next-PC multiplexer output
- o_pc  out  PC_WIDTH  current PC, to instruction memory
- o_pc_plus4  out  PC_WIDTH  o_pc + 4, to multiplexer input 0
- o_target  out  PC_WIDTH  latched target, to multiplexer input 1
- o_select  out  1  multiplexer select; 1 = take target
- o_flush  out  1  squash the IF/ID instruction (redirect applied this cycle)
- o_halted  out  1  core frozen in HALTED
- o_cycle_count  out  PC_WIDTH  number of PC advances since reset

## Operation
- States:
  - IDLE: PC held; waits for i_run or i_step.
  - RUN: PC advances while i_run is high.
  - STEP: performs exactly one advance.
  - HALTED: terminal state.
- Transitions, evaluated in priority order:
  1. From RUN or STEP: i_halt → HALTED.
  2. From IDLE: i_run → RUN; otherwise i_step → STEP.
  3. From RUN: i_run low → IDLE.
  4. From STEP: a completed advance → IDLE.
  5. HALTED is left only by reset.
- Advance condition: adv = ((state == RUN && i_run) || state == STEP) && !i_stall && !i_halt.
- On adv:
  - PC ← i_next_pc.
  - o_cycle_count increments, wrapping modulo 2^PC_WIDTH.
- Redirect tracking:
  - i_branch_valid sets the pending flag and loads target ← {i_branch_target[PC_WIDTH-1:2], 2'b00}.
  - o_select = pending.
  - o_target = target register.
- Applying a redirect:
  - If adv is high while pending is set, PC takes the target through the multiplexer.
  - o_flush = adv && pending (combinational).
  - pending clears unless i_branch_valid is high in the same cycle. In that case pending stays set and the new target is loaded, so the newest branch wins.
- i_branch_valid while pending is already set and not applied (stall or IDLE): the target is overwritten by the newer value.
- i_branch_valid is accepted in every state except HALTED, where it is ignored.
- o_pc_plus4 = o_pc + 4, truncated to PC_WIDTH (wraps from all-ones region to low addresses).
- o_halted = (state == HALTED).
- i_step outside IDLE is ignored. i_run and i_step together in IDLE select RUN.

## Timing
- Reset values (immediate, asynchronous):
  - o_pc = RESET_PC; o_pc_plus4 = RESET_PC + 4
  - o_target = 0; o_select = 0; o_flush = 0
  - o_halted = 0; o_cycle_count = 0
  - state = IDLE
- Reset asserted mid-operation discards any pending redirect and leaves HALTED.
- PC latency: o_pc shows the new value one clock after the adv cycle.
- Redirect latency: o_select rises the cycle after the i_branch_valid edge. The redirect is applied on the first subsequent adv cycle. The target appears on o_pc one clock later.
- IDLE→RUN: the first advance occurs in the cycle after i_run is sampled high in IDLE.
- STEP: exactly one PC change per i_step pulse, however many stall cycles intervene.
- i_halt: the PC does not advance in the cycle i_halt is high. o_halted is high from the next cycle.
- o_flush is valid only in the adv cycle; the IF/ID register samples it on the same edge.

## Test plan
- Reset, then i_run=1 for 4 cycles: o_pc goes 0→4→8→C→10; o_cycle_count = 4; o_select = 0 throughout.
- While running at PC=0x10, pulse i_branch_valid with target 0x43: o_select = 1 and o_target = 0x40 next cycle; o_flush pulses; o_pc = 0x40 one cycle later; o_select returns to 0.
- Branch to 0x80 with i_stall held for 3 cycles: o_pc is held, o_select stays 1, o_flush stays 0; the first unstalled cycle loads 0x80 and flushes once. A second branch to 0xA0 during the stall leaves 0xA0 as the PC.
- From IDLE, pulse i_step with i_stall high for 2 cycles: o_pc advances by exactly 4, once, then the state returns to IDLE and o_pc holds.
- Running, assert i_halt at PC=0x20: o_pc stays 0x20 and o_halted = 1. Later i_run, i_step and i_branch_valid have no effect. Asynchronous reset mid-cycle restores o_pc = RESET_PC and o_halted = 0.
- Set RESET_PC = 0xFFFFFFFC and run 1 cycle: o_pc_plus4 = 0x00000000 at reset; o_pc = 0 after one advance.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage: holds the PC, feeds both
// inputs and the select of the external next-PC multiplexer, tracks one
// pending branch/jump redirect, and runs the debug run/step/halt FSM.
module pc_sequencer #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_run,
    input  logic                i_step,
    input  logic                i_stall,
    input  logic                i_halt,
    input  logic                i_branch_valid,
    input  logic [PC_WIDTH-1:0] i_branch_target,
    input  logic [PC_WIDTH-1:0] i_next_pc,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic [PC_WIDTH-1:0] o_pc_plus4,
    output logic [PC_WIDTH-1:0] o_target,
    output logic                o_select,
    output logic                o_flush,
    output logic                o_halted,
    output logic [PC_WIDTH-1:0] o_cycle_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_e;

    localparam logic [PC_WIDTH-1:0] PC_INC    = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] COUNT_INC = PC_WIDTH'(1);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] target_q, target_d;
    logic                pending_q, pending_d;
    logic [PC_WIDTH-1:0] count_q, count_d;
    logic                adv;
    logic                branch_accept;

    // Targets are word aligned; the two low address bits are dropped.
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^i_branch_target[1:0];

    // Advance qualifier and branch acceptance for the current cycle.
    always_comb begin
        adv           = ((state_q == RUN && i_run) || state_q == STEP) && !i_stall && !i_halt;
        branch_accept = i_branch_valid && (state_q != HALTED);
    end

    // Next-state logic for the run/step/halt FSM, halt taking priority.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_run) begin
                    state_d = RUN;
                end else if (i_step) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (i_halt) begin
                    state_d = HALTED;
                end else if (!i_run) begin
                    state_d = IDLE;
                end
            end
            STEP: begin
                if (i_halt) begin
                    state_d = HALTED;
                end else if (adv) begin
                    state_d = IDLE;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    // PC, cycle counter and redirect-tracking next values.
    always_comb begin
        pc_d      = pc_q;
        count_d   = count_q;
        target_d  = target_q;
        pending_d = pending_q;
        if (adv) begin
            pc_d    = i_next_pc;
            count_d = count_q + COUNT_INC;
        end
        // A new branch always wins over clearing the one being applied now.
        if (branch_accept) begin
            pending_d = 1'b1;
            target_d  = {i_branch_target[PC_WIDTH-1:2], 2'b00};
        end else if (adv && pending_q) begin
            pending_d = 1'b0;
        end
    end

    // State registers; reset discards any pending redirect and leaves HALTED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            target_q  <= '0;
            pending_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            target_q  <= target_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign o_pc          = pc_q;
    assign o_pc_plus4    = pc_q + PC_INC;
    assign o_target      = target_q;
    assign o_select      = pending_q;
    assign o_flush       = adv && pending_q;
    assign o_halted      = (state_q == HALTED);
    assign o_cycle_count = count_q;

endmodule
